// File: rtl/axis_gen_pkg.sv
// Shared types and constants for the AXI-Stream packet generator.
package axis_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } gen_state_e;

  localparam logic MODE_INC  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [7:0]  LFSR_SEED_8  = 8'hFF;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [15:0] LFSR_SEED_16 = 16'hFFFF;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_32 = 32'hFFFF_FFFF;

  // Maximal-length Fibonacci tap mask for the supported data widths.
  function automatic logic [31:0] default_taps(input int unsigned w);
    case (w)
      16:      return 32'(LFSR_TAPS_16);
      32:      return LFSR_TAPS_32;
      default: return 32'(LFSR_TAPS_8);
    endcase
  endfunction

  function automatic logic [31:0] default_seed(input int unsigned w);
    case (w)
      16:      return 32'(LFSR_SEED_16);
      32:      return LFSR_SEED_32;
      default: return 32'(LFSR_SEED_8);
    endcase
  endfunction

endpackage

// File: rtl/axis_gen_datasrc.sv
// Payload source: incrementing counter or Fibonacci LFSR, advanced once per accepted beat.
module axis_gen_datasrc
  import axis_gen_pkg::*;
#(
  parameter int unsigned          data_bits = 8,
  parameter logic [data_bits-1:0] lfsr_taps = data_bits'(default_taps(data_bits)),
  parameter logic [data_bits-1:0] lfsr_seed = data_bits'(default_seed(data_bits))
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 adv,
  input  logic                 mode,
  output logic [data_bits-1:0] data
);

  logic                 r_mode;
  logic [data_bits-1:0] r_data;
  logic [data_bits-1:0] w_data_nxt;

  // Mode is captured on load so a run keeps one data pattern throughout.
  always_comb begin
    w_data_nxt = r_data;
    if (load) begin
      w_data_nxt = (mode == MODE_LFSR) ? lfsr_seed : '0;
    end else if (adv) begin
      if (r_mode == MODE_LFSR) begin
        w_data_nxt = {r_data[data_bits-2:0], ^(r_data & lfsr_taps)};
      end else begin
        w_data_nxt = r_data + data_bits'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_INC;
      r_data <= '0;
    end else begin
      if (load) begin
        r_mode <= mode;
      end
      r_data <= w_data_nxt;
    end
  end

  assign data = r_data;

endmodule

// File: rtl/axis_packet_gen.sv
// AXI-Stream traffic master: emits pkt_num packets of pkt_len beats with
// programmable inter-packet gaps, honouring tready back-pressure.
module axis_packet_gen
  import axis_gen_pkg::*;
#(
  parameter int unsigned          data_bits   = 8,
  parameter int unsigned          tkeep_width = data_bits / 8,
  parameter int unsigned          len_bits    = 8,
  parameter int unsigned          gap_bits    = 4,
  parameter logic [data_bits-1:0] lfsr_taps   = data_bits'(default_taps(data_bits)),
  parameter logic [data_bits-1:0] lfsr_seed   = data_bits'(default_seed(data_bits))
) (
  input  logic                   axis_clk,
  input  logic                   axis_resetn,
  input  logic                   start,
  input  logic                   mode,
  input  logic [len_bits-1:0]    pkt_len,
  input  logic [len_bits-1:0]    pkt_num,
  input  logic [gap_bits-1:0]    gap_cycles,
  output logic                   busy,
  output logic                   done,
  output logic [data_bits-1:0]   m_axis_tdata,
  output logic [tkeep_width-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  gen_state_e            r_state;
  gen_state_e            w_state_nxt;
  logic                  r_start_pend;
  logic [len_bits-1:0]   r_len;
  logic [len_bits-1:0]   r_num;
  logic [gap_bits-1:0]   r_gap;
  logic [len_bits-1:0]   r_beat_cnt;
  logic [len_bits-1:0]   w_beat_nxt;
  logic [len_bits-1:0]   r_pkt_cnt;
  logic [len_bits-1:0]   w_pkt_nxt;
  logic [gap_bits-1:0]   r_gap_cnt;
  logic [gap_bits-1:0]   w_gap_nxt;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [tkeep_width-1:0] r_tkeep;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_adv;

  // start is taken only from a quiet IDLE; the pending cycle gives the one-cycle launch latency.
  assign w_accept = (r_state == IDLE) && !r_start_pend && start;
  assign w_xfer   = r_tvalid && m_axis_tready;

  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_pkt_nxt   = r_pkt_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_adv       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_start_pend) begin
          w_beat_nxt  = '0;
          w_pkt_nxt   = '0;
          w_state_nxt = ((r_len == '0) || (r_num == '0)) ? FIN : SEND;
        end
      end
      SEND: begin
        if (w_xfer) begin
          w_adv = 1'b1;
          if (r_tlast) begin
            w_beat_nxt = '0;
            w_pkt_nxt  = r_pkt_cnt + len_bits'(1);
            if (r_pkt_cnt == r_num - len_bits'(1)) begin
              w_state_nxt = FIN;
            end else if (r_gap != '0) begin
              w_state_nxt = GAP;
              w_gap_nxt   = r_gap;
            end
          end else begin
            w_beat_nxt = r_beat_cnt + len_bits'(1);
          end
        end
      end
      GAP: begin
        if (r_gap_cnt <= gap_bits'(1)) begin
          w_state_nxt = SEND;
        end else begin
          w_gap_nxt = r_gap_cnt - gap_bits'(1);
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with r_state.
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_start_pend <= 1'b0;
      r_len        <= '0;
      r_num        <= '0;
      r_gap        <= '0;
      r_beat_cnt   <= '0;
      r_pkt_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tkeep      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_start_pend <= w_accept;
      if (w_accept) begin
        r_len <= pkt_len;
        r_num <= pkt_num;
        r_gap <= gap_cycles;
      end
      r_beat_cnt <= w_beat_nxt;
      r_pkt_cnt  <= w_pkt_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_tvalid   <= (w_state_nxt == SEND);
      r_tkeep    <= (w_state_nxt == SEND) ? '1 : '0;
      r_tlast    <= (w_state_nxt == SEND) && (w_beat_nxt == r_len - len_bits'(1));
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == FIN);
    end
  end

  axis_gen_datasrc #(
    .data_bits (data_bits),
    .lfsr_taps (lfsr_taps),
    .lfsr_seed (lfsr_seed)
  ) u_datasrc (
    .clk   (axis_clk),
    .rst_n (axis_resetn),
    .load  (w_accept),
    .adv   (w_adv),
    .mode  (mode),
    .data  (m_axis_tdata)
  );

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tkeep  = r_tkeep;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Randomised scenario bench for axis_packet_gen against a list-based traffic model.
module tb_axis_packet_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned KW = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic [7:0]    pkt_len;
  logic [7:0]    pkt_num;
  logic [3:0]    gap_cycles;
  logic          busy;
  logic          done;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_data[$];
  bit         exp_last[$];
  logic [7:0] obs_data[$];
  bit         obs_last[$];
  int         obs_gaps[$];
  int         first_valid;
  int         done_cyc;
  int         done_cnt;
  int         hold_viol;
  int         keep_bad;
  int         busy_bad;

  always #5 clk = ~clk;

  axis_packet_gen dut (
    .axis_clk      (clk),
    .axis_resetn   (rst_n),
    .start         (start),
    .mode          (mode),
    .pkt_len       (pkt_len),
    .pkt_num       (pkt_num),
    .gap_cycles    (gap_cycles),
    .busy          (busy),
    .done          (done),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready)
  );

  // Reference run: beat i of the run carries i (mode 0) or the i-th LFSR state from FF.
  function automatic void build_expected(input logic md, input int len, input int num);
    int lfsr;
    lfsr = 'hFF;
    exp_data.delete();
    exp_last.delete();
    for (int i = 0; i < len * num; i++) begin
      exp_data.push_back(md ? 8'(lfsr) : 8'(i % 256));
      exp_last.push_back(bit'((i % len) == len - 1));
      lfsr = ((lfsr << 1) | ($countones(lfsr & 'hB8) % 2)) & 'hFF;
    end
  endfunction

  // Launches one run and records what the stream did; bp<0 stalls beat 01 for 3 cycles.
  task automatic run_traffic(input logic md, input int len, input int num, input int gap,
                             input int bp, input bit mid_start);
    logic [7:0] prev_data;
    logic       prev_last;
    bit         prev_stall;
    bit         seen_last;
    int         idle_run;
    int         stall_left;
    bit         exp_busy;
    obs_data.delete();
    obs_last.delete();
    obs_gaps.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0;
    hold_viol = 0; keep_bad = 0; busy_bad = 0;
    prev_data = '0; prev_last = 1'b0; prev_stall = 1'b0;
    seen_last = 1'b0; idle_run = 0; stall_left = 3;
    @(negedge clk);
    mode = md; pkt_len = 8'(len); pkt_num = 8'(num); gap_cycles = 4'(gap);
    tready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (tvalid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last)) hold_viol++;
      if (tkeep !== {KW{tvalid}}) keep_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      exp_busy = (cyc >= 2) && (done_cyc < 0 || cyc <= done_cyc);
      if (busy !== exp_busy) busy_bad++;
      if (seen_last && tvalid) begin
        obs_gaps.push_back(idle_run);
        idle_run = 0;
        seen_last = 1'b0;
      end else if (seen_last && !done) begin
        idle_run++;
      end
      if (bp < 0) begin
        tready = !(tvalid && tdata == 8'h01 && stall_left > 0);
        if (!tready) stall_left--;
      end else begin
        tready = ($urandom_range(99) >= bp);
      end
      start = mid_start && (cyc == 4);
      if (start) begin
        mode = ~md; pkt_len = 8'd1; gap_cycles = 4'd0;
      end
      if (tvalid && tready) begin
        obs_data.push_back(tdata);
        obs_last.push_back(tlast);
        if (tlast) seen_last = 1'b1;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    tready = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if ({tvalid, tlast, tkeep, tdata, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got v=%b l=%b k=%h d=%h busy=%b done=%b, want all 0",
               tvalid, tlast, tkeep, tdata, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got busy=%b tvalid=%b, want 0 0", busy, tvalid);
    end
  endtask

  task automatic test_inc_single;
    run_traffic(1'b0, 4, 1, 0, 0, 1'b0);
    build_expected(1'b0, 4, 1);
    vectors++;
    if (obs_data.size() != exp_data.size()) begin
      miscompares++;
      $display("FAIL inc_beats: got %0d want %0d", obs_data.size(), exp_data.size());
    end
    foreach (exp_data[i]) if (i < obs_data.size()) begin
      vectors++;
      if ({obs_last[i], obs_data[i]} !== {exp_last[i], exp_data[i]}) begin
        miscompares++;
        $display("FAIL inc_beat%0d: got last=%b data=%h want last=%b data=%h",
                 i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
      end
    end
    vectors++;
    if (first_valid != 2 || done_cyc != 6 || done_cnt != 1 || busy_bad != 0) begin
      miscompares++;
      $display("FAIL inc_timing: got first=%0d done@%0d x%0d busy_bad=%0d want 2 6 1 0",
               first_valid, done_cyc, done_cnt, busy_bad);
    end
  endtask

  task automatic test_lfsr;
    run_traffic(1'b1, 6, 1, 0, 0, 1'b0);
    build_expected(1'b1, 6, 1);
    vectors++;
    if (obs_data.size() != 6 || obs_data[0] !== 8'hFF || obs_data[5] !== 8'hE1) begin
      miscompares++;
      $display("FAIL lfsr_ends: got n=%0d, want 6 beats FF..E1", obs_data.size());
    end
    foreach (exp_data[i]) if (i < obs_data.size()) begin
      vectors++;
      if ({obs_last[i], obs_data[i]} !== {exp_last[i], exp_data[i]}) begin
        miscompares++;
        $display("FAIL lfsr_beat%0d: got last=%b data=%h want last=%b data=%h",
                 i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_gap;
    run_traffic(1'b0, 3, 2, 2, 0, 1'b0);
    build_expected(1'b0, 3, 2);
    foreach (exp_data[i]) if (i < obs_data.size()) begin
      vectors++;
      if ({obs_last[i], obs_data[i]} !== {exp_last[i], exp_data[i]}) begin
        miscompares++;
        $display("FAIL gap_beat%0d: got last=%b data=%h want last=%b data=%h",
                 i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
      end
    end
    vectors++;
    if (obs_data.size() != 6 || obs_gaps.size() != 1 || (obs_gaps.size() == 1 && obs_gaps[0] != 2)) begin
      miscompares++;
      $display("FAIL gap_idle: got beats=%0d gaps=%0d, want 6 beats, one gap of 2",
               obs_data.size(), obs_gaps.size());
    end
    vectors++;
    if (done_cyc != 10) begin
      miscompares++;
      $display("FAIL gap_done: got cycle %0d want 10", done_cyc);
    end
  endtask

  task automatic test_back_to_back;
    run_traffic(1'b0, 3, 2, 0, 0, 1'b0);
    build_expected(1'b0, 3, 2);
    foreach (exp_data[i]) if (i < obs_data.size()) begin
      vectors++;
      if ({obs_last[i], obs_data[i]} !== {exp_last[i], exp_data[i]}) begin
        miscompares++;
        $display("FAIL b2b_beat%0d: got last=%b data=%h want last=%b data=%h",
                 i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
      end
    end
    vectors++;
    if (obs_data.size() != 6 || obs_gaps.size() != 1 || done_cyc != 8 ||
        (obs_gaps.size() == 1 && obs_gaps[0] != 0)) begin
      miscompares++;
      $display("FAIL b2b_timing: got beats=%0d done@%0d, want 6 contiguous beats, done@8",
               obs_data.size(), done_cyc);
    end
  endtask

  task automatic test_backpressure;
    run_traffic(1'b0, 4, 1, 0, -1, 1'b0);
    build_expected(1'b0, 4, 1);
    vectors++;
    if (obs_data.size() != 4) begin
      miscompares++;
      $display("FAIL bp_beats: got %0d want 4", obs_data.size());
    end
    foreach (exp_data[i]) if (i < obs_data.size()) begin
      vectors++;
      if ({obs_last[i], obs_data[i]} !== {exp_last[i], exp_data[i]}) begin
        miscompares++;
        $display("FAIL bp_beat%0d: got last=%b data=%h want last=%b data=%h",
                 i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
      end
    end
    vectors++;
    if (hold_viol != 0 || keep_bad != 0 || done_cyc != 9) begin
      miscompares++;
      $display("FAIL bp_hold: got hold_viol=%0d keep_bad=%0d done@%0d want 0 0 9",
               hold_viol, keep_bad, done_cyc);
    end
  endtask

  task automatic test_zero_len;
    run_traffic(1'b0, 0, 3, 1, 0, 1'b0);
    vectors++;
    if (obs_data.size() != 0 || first_valid != -1 || done_cyc != 2 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL zero_len: got beats=%0d first=%0d done@%0d x%0d want 0 -1 2 1",
               obs_data.size(), first_valid, done_cyc, done_cnt);
    end
    run_traffic(1'b1, 5, 0, 0, 0, 1'b0);
    vectors++;
    if (obs_data.size() != 0 || done_cyc != 2 || busy_bad != 0) begin
      miscompares++;
      $display("FAIL zero_num: got beats=%0d done@%0d busy_bad=%0d want 0 2 0",
               obs_data.size(), done_cyc, busy_bad);
    end
  endtask

  task automatic test_start_while_busy;
    run_traffic(1'b0, 5, 2, 1, 0, 1'b1);
    build_expected(1'b0, 5, 2);
    vectors++;
    if (obs_data.size() != 10 || done_cyc != 13 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL busy_start: got beats=%0d done@%0d x%0d want 10 13 1",
               obs_data.size(), done_cyc, done_cnt);
    end
    foreach (exp_data[i]) if (i < obs_data.size()) begin
      vectors++;
      if ({obs_last[i], obs_data[i]} !== {exp_last[i], exp_data[i]}) begin
        miscompares++;
        $display("FAIL busy_beat%0d: got last=%b data=%h want last=%b data=%h",
                 i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_requeue: got busy=%b tvalid=%b want 0 0", busy, tvalid);
    end
  endtask

  task automatic test_reset_midrun;
    bit hit;
    bit done_seen;
    @(negedge clk);
    mode = 1'b0; pkt_len = 8'd4; pkt_num = 8'd1; gap_cycles = 4'd0; tready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 20 && !(tvalid && tdata == 8'h02); n++) @(negedge clk);
    hit = tvalid && (tdata == 8'h02);
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL rst_reach_beat2: got tvalid=%b tdata=%h want 1 02", tvalid, tdata);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || tdata !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_async: got tvalid=%b busy=%b tdata=%h want 0 0 00", tvalid, busy, tdata);
    end
    done_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    vectors++;
    if (done_seen) begin
      miscompares++;
      $display("FAIL rst_no_done: got done/busy after abort, want none");
    end
    run_traffic(1'b0, 4, 1, 0, 0, 1'b0);
    vectors++;
    if (obs_data.size() != 4 || (obs_data.size() > 0 && obs_data[0] !== 8'h00)) begin
      miscompares++;
      $display("FAIL rst_restart: got beats=%0d first=%h want 4 00",
               obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 8'hxx);
    end
  endtask

  task automatic test_random;
    logic md;
    int   len;
    int   num;
    int   gap;
    for (int it = 0; it < 6; it++) begin
      md  = 1'($urandom_range(1));
      len = int'($urandom_range(9, 1));
      num = int'($urandom_range(4, 1));
      gap = int'($urandom_range(3, 0));
      run_traffic(md, len, num, gap, 30, 1'b0);
      build_expected(md, len, num);
      vectors++;
      if (obs_data.size() != exp_data.size() || done_cnt != 1 || hold_viol != 0 ||
          keep_bad != 0 || busy_bad != 0 || obs_gaps.size() != num - 1) begin
        miscompares++;
        $display("FAIL rand%0d_run: beats=%0d/%0d done=%0d hold=%0d keep=%0d busy=%0d gaps=%0d/%0d",
                 it, obs_data.size(), exp_data.size(), done_cnt, hold_viol, keep_bad,
                 busy_bad, obs_gaps.size(), num - 1);
      end
      foreach (obs_gaps[g]) begin
        vectors++;
        if (obs_gaps[g] != gap) begin
          miscompares++;
          $display("FAIL rand%0d_gap%0d: got %0d want %0d", it, g, obs_gaps[g], gap);
        end
      end
      foreach (exp_data[i]) if (i < obs_data.size()) begin
        vectors++;
        if ({obs_last[i], obs_data[i]} !== {exp_last[i], exp_data[i]}) begin
          miscompares++;
          $display("FAIL rand%0d_beat%0d: got last=%b data=%h want last=%b data=%h",
                   it, i, obs_last[i], obs_data[i], exp_last[i], exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; pkt_len = '0; pkt_num = '0;
    gap_cycles = '0; tready = 1'b1;
    test_reset;
    test_inc_single;
    test_lfsr;
    test_gap;
    test_back_to_back;
    test_backpressure;
    test_zero_len;
    test_start_while_busy;
    test_reset_midrun;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
